// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates instruction-fetch and data requests onto one synchronous memory port.
//   Ports:
//     clk, rst                      clock (rising edge), asynchronous active-low reset
//     if_req/if_addr                fetch request; if_gnt, if_rvalid, if_rdata back to fetch
//     dm_req/dm_we/dm_addr/dm_wdata data request; dm_gnt, dm_rvalid, dm_rdata back to data port
//     mem_en/mem_we/mem_addr/mem_wdata/mem_rdata   single-ported memory, 1-cycle read latency
//     stall_if                      fetch requesting but not granted
//     conflict_cnt                  saturating count of cycles with both requesting
//                                   (only when MEM_ARB_STATS_EN is defined)
module mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_DATA_RUN = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_if
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [15:0]       conflict_cnt
`endif
);
  localparam int RW = MAX_DATA_RUN > 0 ? $clog2(MAX_DATA_RUN + 1) : 1;
  localparam logic [RW-1:0] RUN_MAX = RW'(MAX_DATA_RUN);
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_DM} owner_t;
  owner_t owner_q, owner_d;
  logic [RW-1:0] run_cnt_q, run_cnt_d;
  logic if_wins;
  // run_cnt never exceeds RUN_MAX, so equality means the data run is exhausted;
  // with MAX_DATA_RUN=0 it is always true and fetch has absolute priority.
  always_comb begin
    if_wins   = run_cnt_q == RUN_MAX;
    if_gnt    = rst & if_req & (~dm_req | if_wins);
    dm_gnt    = rst & dm_req & ~(if_req & if_wins);
    stall_if  = rst & if_req & ~if_gnt;
    mem_en    = if_gnt | dm_gnt;
    mem_we    = dm_gnt & dm_we;
    mem_addr  = if_gnt ? if_addr : dm_gnt ? dm_addr : '0;
    mem_wdata = dm_gnt ? dm_wdata : '0;
    run_cnt_d = (~if_req | if_gnt) ? '0 : dm_gnt ? run_cnt_q + 1'b1 : run_cnt_q;
    owner_d   = if_gnt ? OWN_IF : (dm_gnt & ~dm_we) ? OWN_DM : OWN_NONE;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_q   <= OWN_NONE;
      run_cnt_q <= '0;
    end else begin
      owner_q   <= owner_d;
      run_cnt_q <= run_cnt_d;
    end
  end
  assign if_rvalid = owner_q == OWN_IF;
  assign dm_rvalid = owner_q == OWN_DM;
  assign if_rdata  = mem_rdata;
  assign dm_rdata  = mem_rdata;
`ifdef MEM_ARB_STATS_EN
  logic [15:0] conflict_cnt_q, conflict_cnt_d;
  always_comb conflict_cnt_d = (if_req & dm_req & ~&conflict_cnt_q) ? conflict_cnt_q + 16'd1 : conflict_cnt_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) conflict_cnt_q <= '0;
    else      conflict_cnt_q <= conflict_cnt_d;
  end
  assign conflict_cnt = conflict_cnt_q;
`endif
endmodule
